// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-requester arbiter.
package arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin
// starting just after i_last_id with wrap-around.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_request,
    input  logic [IDW-1:0]     i_last_id,
    input  logic               i_rr_mode,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDW-1:0]     o_idx,
    output logic               o_any
);

    assign o_any = |i_request;

    // Each requester gets a distance from the search start; the smallest
    // distance among active requests wins.
    always_comb begin
        int w_dist;
        int w_best;
        o_pick = '0;
        o_idx  = '0;
        w_dist = 0;
        w_best = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_rr_mode) begin
                w_dist = i - int'(i_last_id) - 1;
                if (w_dist < 0) begin
                    w_dist = w_dist + NUM_REQ;
                end
            end else begin
                w_dist = i;
            end
            if (i_request[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                o_pick    = '0;
                o_pick[i] = 1'b1;
                o_idx     = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester arbiter with registered one-hot grant, binary grant index,
// round-robin or fixed priority, and optional grant hold.
//
// state   | meaning
// IDLE    | no grant outstanding, outputs zero
// GRANTED | one requester owns the resource
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RR_MODE = 1,
    parameter int HOLD_EN = 1,
    localparam int IDW    = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] request,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id
);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_grant_valid;
    logic [IDW-1:0]     r_grant_id;
    logic [IDW-1:0]     r_last_id;

    logic [NUM_REQ-1:0] w_pick;
    logic [IDW-1:0]     w_idx;
    logic               w_any;
    logic               w_hold;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .i_request (request),
        .i_last_id (r_last_id),
        .i_rr_mode (RR_MODE != 0),
        .o_pick    (w_pick),
        .o_idx     (w_idx),
        .o_any     (w_any)
    );

    assign w_hold = (HOLD_EN != 0) && (r_state == GRANTED) && request[r_grant_id];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last_id     <= IDW'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant       <= w_pick;
                        r_grant_id    <= w_idx;
                        r_last_id     <= w_idx;
                        r_grant_valid <= 1'b1;
                        r_state       <= GRANTED;
                    end
                end
                GRANTED: begin
                    // Without hold the current owner is just another requester,
                    // and the pointer makes it lowest priority in RR mode.
                    if (!w_hold) begin
                        if (w_any) begin
                            r_grant       <= w_pick;
                            r_grant_id    <= w_idx;
                            r_last_id     <= w_idx;
                            r_grant_valid <= 1'b1;
                        end else begin
                            r_grant       <= '0;
                            r_grant_id    <= '0;
                            r_grant_valid <= 1'b0;
                            r_state       <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench: four arbiter configurations driven by one shared request
// vector, expected grants computed by hand.
module tb_rr_arbiter_n;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;

    logic [3:0] g_rr, g_hold, g_fix;
    logic       v_rr, v_hold, v_fix;
    logic [1:0] id_rr, id_hold, id_fix;
    logic       g_one, v_one, id_one;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    rr_arbiter_n #(.NUM_REQ(4), .RR_MODE(1), .HOLD_EN(0)) dut_rr (
        .clk(clk), .reset(reset), .request(request),
        .grant(g_rr), .grant_valid(v_rr), .grant_id(id_rr));

    rr_arbiter_n #(.NUM_REQ(4), .RR_MODE(1), .HOLD_EN(1)) dut_hold (
        .clk(clk), .reset(reset), .request(request),
        .grant(g_hold), .grant_valid(v_hold), .grant_id(id_hold));

    rr_arbiter_n #(.NUM_REQ(4), .RR_MODE(0), .HOLD_EN(1)) dut_fix (
        .clk(clk), .reset(reset), .request(request),
        .grant(g_fix), .grant_valid(v_fix), .grant_id(id_fix));

    rr_arbiter_n #(.NUM_REQ(1), .RR_MODE(1), .HOLD_EN(1)) dut_one (
        .clk(clk), .reset(reset), .request(request[0]),
        .grant(g_one), .grant_valid(v_one), .grant_id(id_one));

    localparam logic [3:0] ROT [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                       4'b0001, 4'b0010, 4'b0100, 4'b1000};
    localparam logic [3:0] RR_HOLDPHASE [5] = '{4'b0001, 4'b0010, 4'b0100,
                                                4'b0001, 4'b0010};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic check_arb(input string tag, input logic [3:0] g, input logic v,
                             input logic [1:0] id, input logic [3:0] exp_g);
        check({tag, ".grant"}, 32'(g), 32'(exp_g));
        check({tag, ".valid"}, 32'(v), 32'(|exp_g));
        check({tag, ".id"}, 32'(id), 32'(onehot_idx(exp_g)));
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic [3:0] req, input logic rst_n);
        @(negedge clk);
        request = req;
        reset   = rst_n;
        @(posedge clk);
        #1;
        check("one.grant", 32'(g_one), 32'(rst_n & req[0]));
        check("one.valid", 32'(v_one), 32'(rst_n & req[0]));
        check("one.id", 32'(id_one), 32'(0));
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_rr,
                             input logic [3:0] e_hold, input logic [3:0] e_fix);
        check_arb({tag, ".rr"}, g_rr, v_rr, id_rr, e_rr);
        check_arb({tag, ".hold"}, g_hold, v_hold, id_hold, e_hold);
        check_arb({tag, ".fix"}, g_fix, v_fix, id_fix, e_fix);
    endtask

    initial begin
        reset   = 1'b0;
        request = 4'b0000;

        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0);
            check_all("reset", 4'b0000, 4'b0000, 4'b0000);
        end

        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b1);
            check_all($sformatf("rot%0d", i), ROT[i], 4'b0001, 4'b0001);
        end

        step(4'b0000, 1'b1);
        check_all("idle0", 4'b0000, 4'b0000, 4'b0000);

        step(4'b0100, 1'b1);
        check_all("hold_start", 4'b0100, 4'b0100, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            step(4'b0111, 1'b1);
            check_all($sformatf("hold%0d", i), RR_HOLDPHASE[i], 4'b0100, 4'b0100);
        end
        step(4'b0011, 1'b1);
        check_all("hold_drop", 4'b0001, 4'b0001, 4'b0001);

        step(4'b1010, 1'b1);
        check_all("fix_a", 4'b0010, 4'b0010, 4'b0010);
        step(4'b1000, 1'b1);
        check_all("fix_b", 4'b1000, 4'b1000, 4'b1000);

        step(4'b0010, 1'b1);
        check_all("idle_pre", 4'b0010, 4'b0010, 4'b0010);
        step(4'b0000, 1'b1);
        check_all("idle_ret", 4'b0000, 4'b0000, 4'b0000);
        step(4'b1000, 1'b1);
        check_all("idle_new", 4'b1000, 4'b1000, 4'b1000);

        step(4'b0100, 1'b1);
        check_all("mid_a", 4'b0100, 4'b0100, 4'b0100);
        step(4'b1100, 1'b1);
        check_all("mid_b", 4'b1000, 4'b0100, 4'b0100);
        step(4'b1100, 1'b0);
        check_all("mid_rst", 4'b0000, 4'b0000, 4'b0000);
        step(4'b1100, 1'b1);
        check_all("mid_rel", 4'b0100, 4'b0100, 4'b0100);

        step(4'b0000, 1'b1);
        check_all("pulse_pre", 4'b0000, 4'b0000, 4'b0000);
        step(4'b0010, 1'b1);
        check_all("pulse_on", 4'b0010, 4'b0010, 4'b0010);
        step(4'b0000, 1'b1);
        check_all("pulse_off", 4'b0000, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
